param_cfg_loader: RTL and testbench
===================================

Name: param_cfg_loader

Overview:
- Byte-stream configuration loader. Receives framed writes over a valid/ready byte interface and builds a bank of NUM_ENTRIES parameter registers.
- Sits directly upstream of the parameterised datapath modules. Drives their runtime parameter values and signals each committed update.
- Frames with a bad checksum, an out-of-range index or a mid-frame stall are dropped whole and flagged.

Parameters:
- NUM_ENTRIES, 8, number of parameter registers (2..256).
- ENTRY_W, 32, width of each register in bits (8..64).
- DEFAULT_VAL, '0, value of every entry after reset (ENTRY_W bits).
- TIMEOUT_CYC, 16, maximum idle cycles between bytes inside a frame (>=1).
- Derived localparam BYTES = ceil(ENTRY_W/8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  byte valid.
- in_data  in  8  byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- cfg_values  out  NUM_ENTRIES*ENTRY_W  flat register bank; entry i occupies bits [i*ENTRY_W +: ENTRY_W].
- cfg_update  out  1  one-cycle pulse when an entry is committed.
- cfg_upd_idx  out  $clog2(NUM_ENTRIES)  index of the committed entry; valid with cfg_update.
- err  out  1  one-cycle pulse when a frame is dropped.
- err_code  out  2  01 = checksum, 10 = bad index, 11 = timeout; valid with err.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All entries = DEFAULT_VAL.
  - cfg_update = 0, cfg_upd_idx = 0, err = 0, err_code = 0.
  - in_ready = 0 during reset; 1 in the first cycle after reset is released.
  - FSM = IDLE.
  - A frame in progress when reset asserts is discarded silently.
- Frame format: SYNC (0xA5), IDX, D0..D(BYTES-1) little-endian, CSUM.
  - CSUM = IDX ^ D0 ^ ... ^ D(BYTES-1).
  - Data bits above ENTRY_W in the last data byte are ignored but still included in CSUM.
- FSM states: IDLE, IDX, DATA, CSUM, COMMIT.
  - IDLE: accepted 0xA5 -> IDX. Any other accepted byte is discarded with no error.
  - IDX: latch the index, initialise the checksum accumulator with it, clear the byte counter -> DATA.
  - DATA: shift each accepted byte into a shadow register. After byte BYTES-1 -> CSUM.
  - CSUM: compare the received byte with the accumulator -> COMMIT.
  - COMMIT: in_ready = 0 for exactly this cycle.
    - Checksum good and index < NUM_ENTRIES: write the entry; cfg_update = 1 and cfg_upd_idx = index in this cycle.
    - Checksum bad: err = 1, err_code = 01. A checksum error takes priority over a bad index.
    - Checksum good, index >= NUM_ENTRIES: err = 1, err_code = 10.
    - Always -> IDLE next cycle.
- Latency: cfg_values shows the new value on the cycle after the COMMIT edge, coincident with cfg_update.
- Apart from the COMMIT cycle, in_ready = 1 in all states.
- Only the addressed entry changes. A commit never produces a partial update.
- Timeout:
  - In IDX, DATA or CSUM, the idle counter increments each cycle with no accepted byte and clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYC -> IDLE, err = 1, err_code = 11.
  - The shadow register is discarded and no entry changes.
  - A byte presented in that same cycle is not accepted (in_ready = 0 on the timeout cycle).
- A 0xA5 byte inside IDX, DATA or CSUM is treated as data, not as a resync.
- Back-to-back frames:
  - A SYNC byte may be offered in the cycle after COMMIT. It is accepted in IDLE at full rate.
  - Steady-state throughput is one frame per BYTES+4 cycles.

Decomposition:
- Package param_cfg_pkg:
  - SYNC_BYTE constant (8'hA5).
  - state_e enum.
  - err_code_e enum (NONE = 00, CSUM = 01, IDX = 10, TIMEOUT = 11).
- Sub-module param_cfg_timeout: loadable idle counter with clear, enable and expire pulse, parameterised by TIMEOUT_CYC.

Test Plan:
- Good frame, ENTRY_W = 32: A5 03 11 22 33 44 47 -> entry3 = 0x44332211, cfg_update pulse with cfg_upd_idx = 3, all other entries unchanged.
- Bad checksum: A5 03 11 22 33 44 48 -> err pulse, err_code = 01, entry3 unchanged, no cfg_update.
- Bad index, NUM_ENTRIES = 8: A5 09 00 00 00 00 09 -> err_code = 10, no entry written.
- Timeout: A5 02 then in_valid low for 16 cycles -> err_code = 11 on the 16th idle cycle. A following good frame A5 02 01 00 00 00 03 -> entry2 = 0x00000001.
- Noise then back-to-back frames: 00 FF A5 01 AA 00 00 00 AB A5 01 55 00 00 00 54 -> no error, two cfg_update pulses, entry1 ends at 0x00000055, in_ready low exactly one cycle per frame.
- Reset mid-frame: A5 04 11 22 then rst_n low for 1 cycle -> all entries = DEFAULT_VAL, no err or cfg_update. The next frame decodes correctly.

Source files
------------

// File: rtl/param_cfg_pkg.sv
// Shared constants and enumerations for the parameter configuration loader.
package param_cfg_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_IDX    = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_COMMIT = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_CSUM    = 2'b01,
      ERR_IDX     = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_code_e;

endpackage

// File: rtl/param_cfg_timeout.sv
// Inter-byte idle timer: down-counter reloaded on every accepted byte,
// expire is high in the cycle that would be the TIMEOUT_CYC-th idle cycle.
module param_cfg_timeout #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   // Reload on activity or when not inside a frame, otherwise count idle cycles down.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= LOAD_VAL;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/param_cfg_loader.sv
// Framed byte-stream loader for a bank of runtime parameter registers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | hunting for SYNC; other bytes are dropped silently
// S_IDX    | waiting for the index byte
// S_DATA   | collecting BYTES little-endian data bytes into the shadow
// S_CSUM   | waiting for the checksum byte; entry is written on accept
// S_COMMIT | one-cycle result: update pulse or error pulse, not ready
module param_cfg_loader
   import param_cfg_pkg::*;
#(
   parameter int                 NUM_ENTRIES = 8,
   parameter int                 ENTRY_W     = 32,
   parameter logic [ENTRY_W-1:0] DEFAULT_VAL = '0,
   parameter int                 TIMEOUT_CYC = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic [7:0]                     in_data,
   output logic                           in_ready,
   output logic [NUM_ENTRIES*ENTRY_W-1:0] cfg_values,
   output logic                           cfg_update,
   output logic [$clog2(NUM_ENTRIES)-1:0] cfg_upd_idx,
   output logic                           err,
   output logic [1:0]                     err_code
);

   localparam int             IW        = $clog2(NUM_ENTRIES);
   localparam int             BYTES     = (ENTRY_W + 7) / 8;
   localparam int             SW        = BYTES * 8;
   localparam int             BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

   state_e                         state;
   state_e                         state_nxt;
   logic                           accept;
   logic                           active;
   logic                           tmo_expire;
   logic [7:0]                     idx_q;
   logic [7:0]                     csum_acc;
   logic [BCW-1:0]                 bcnt;
   logic [SW-1:0]                  shadow;
   logic                           csum_ok_q;
   logic                           idx_ok_q;
   logic                           idx_in_range;
   logic [NUM_ENTRIES*ENTRY_W-1:0] bank;

   assign active       = (state == S_IDX) || (state == S_DATA) || (state == S_CSUM);
   assign in_ready     = rst_n && (state != S_COMMIT) && !tmo_expire;
   assign accept       = in_valid && in_ready;
   assign idx_in_range = ({1'b0, idx_q} < 9'(NUM_ENTRIES));
   assign cfg_values   = bank;

   param_cfg_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept || !active),
      .en     (active),
      .expire (tmo_expire)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and the one-cycle result pulses.
   always_comb begin
      state_nxt   = state;
      cfg_update  = 1'b0;
      cfg_upd_idx = '0;
      err         = 1'b0;
      err_code    = ERR_NONE;
      if (tmo_expire) begin
         state_nxt = S_IDLE;
         err       = 1'b1;
         err_code  = ERR_TIMEOUT;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && (in_data == SYNC_BYTE)) state_nxt = S_IDX;
            end
            S_IDX: begin
               if (accept) state_nxt = S_DATA;
            end
            S_DATA: begin
               if (accept && (bcnt == LAST_BYTE)) state_nxt = S_CSUM;
            end
            S_CSUM: begin
               if (accept) state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
               state_nxt = S_IDLE;
               if (!csum_ok_q) begin
                  err      = 1'b1;
                  err_code = ERR_CSUM;
               end else if (!idx_ok_q) begin
                  err      = 1'b1;
                  err_code = ERR_IDX;
               end else begin
                  cfg_update  = 1'b1;
                  cfg_upd_idx = idx_q[IW-1:0];
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame datapath; the entry is written on the checksum edge so the new value
   // is visible in the COMMIT cycle together with cfg_update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank      <= {NUM_ENTRIES{DEFAULT_VAL}};
         idx_q     <= '0;
         csum_acc  <= '0;
         bcnt      <= '0;
         shadow    <= '0;
         csum_ok_q <= 1'b0;
         idx_ok_q  <= 1'b0;
      end else if (accept) begin
         case (state)
            S_IDX: begin
               idx_q    <= in_data;
               csum_acc <= in_data;
               bcnt     <= '0;
            end
            S_DATA: begin
               shadow   <= (shadow >> 8) | (SW'(in_data) << (SW - 8));
               csum_acc <= csum_acc ^ in_data;
               bcnt     <= bcnt + 1'b1;
            end
            S_CSUM: begin
               csum_ok_q <= (in_data == csum_acc);
               idx_ok_q  <= idx_in_range;
               if ((in_data == csum_acc) && idx_in_range) begin
                  bank[idx_q[IW-1:0]*ENTRY_W +: ENTRY_W] <= shadow[ENTRY_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_param_cfg_loader.sv
// Self-checking bench: directed frames plus randomized frames against a
// frame-level reference model of the register bank.
module tb_param_cfg_loader;

   localparam int NE = 8;
   localparam int EW = 32;
   localparam int NB = 4;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic [7:0]     in_data = 8'h00;
   logic           in_ready;
   logic [NE*EW-1:0] cfg_values;
   logic           cfg_update;
   logic [2:0]     cfg_upd_idx;
   logic           err;
   logic [1:0]     err_code;

   always #5 clk = ~clk;

   param_cfg_loader #(
      .NUM_ENTRIES (NE),
      .ENTRY_W     (EW),
      .DEFAULT_VAL ('0),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .cfg_values  (cfg_values),
      .cfg_update  (cfg_update),
      .cfg_upd_idx (cfg_upd_idx),
      .err         (err),
      .err_code    (err_code)
   );

   typedef struct {
      bit          is_err;
      int          idx;
      int          code;
      logic [31:0] val;
      longint      c;
   } ev_t;

   int          n_assert = 0;
   int          n_fail = 0;
   longint      cyc = 0;
   longint      last_acc = 0;
   int          rdy_low = 0;
   ev_t         evq[$];
   logic [31:0] mem [NE];

   always @(posedge clk) cyc <= cyc + 1;

   // Record every result pulse and count not-ready cycles outside reset.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         if (!in_ready) rdy_low = rdy_low + 1;
         if (cfg_update) begin
            e.is_err = 1'b0;
            e.idx    = int'(cfg_upd_idx);
            e.code   = 0;
            e.val    = cfg_values[int'(cfg_upd_idx)*EW +: EW];
            e.c      = cyc;
            evq.push_back(e);
         end
         if (err) begin
            e.is_err = 1'b1;
            e.idx    = 0;
            e.code   = int'(err_code);
            e.val    = '0;
            e.c      = cyc;
            evq.push_back(e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) last_acc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("byte_accepted", acc, 1'b1);
   endtask

   task automatic send_frame(input logic [7:0] idx, input logic [31:0] d, input logic [7:0] flip);
      logic [7:0] cs;
      cs = idx ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24] ^ flip;
      send_byte(8'hA5);
      send_byte(idx);
      for (int i = 0; i < NB; i++) send_byte(d[i*8 +: 8]);
      send_byte(cs);
   endtask

   task automatic check_bank();
      for (int i = 0; i < NE; i++)
         chk($sformatf("entry%0d", i), cfg_values[i*EW +: EW], mem[i]);
   endtask

   // Compare the single recorded result against the model's view of the frame.
   task automatic expect_result(input int idx, input logic [31:0] d, input bit csum_ok, input bit timeout);
      ev_t e;
      chk("event_count", evq.size(), 1);
      if (evq.size() >= 1) begin
         e = evq.pop_front();
         if (timeout) begin
            chk("tmo_is_err", e.is_err, 1'b1);
            chk("tmo_code", e.code, 3);
            chk("tmo_latency", e.c - last_acc, TO);
         end else if (!csum_ok) begin
            chk("csum_is_err", e.is_err, 1'b1);
            chk("csum_code", e.code, 1);
         end else if (idx >= NE) begin
            chk("idx_is_err", e.is_err, 1'b1);
            chk("idx_code", e.code, 2);
         end else begin
            chk("upd_not_err", e.is_err, 1'b0);
            chk("upd_idx", e.idx, idx);
            chk("upd_val", e.val, d);
            mem[idx] = d;
         end
      end
      chk("ready_low_cycles", rdy_low, 1);
      evq.delete();
      check_bank();
   endtask

   initial begin
      ev_t        e1;
      ev_t        e2;
      int         m;
      int         r;
      int         idx;
      logic [7:0] b;
      logic [7:0] flip;
      logic [31:0] d;

      for (int i = 0; i < NE; i++) mem[i] = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_values", cfg_values, '0);
      chk("rst_update", cfg_update, 1'b0);
      chk("rst_upd_idx", cfg_upd_idx, 3'd0);
      chk("rst_err", err, 1'b0);
      chk("rst_err_code", err_code, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Good frame to entry 3
      rdy_low = 0;
      send_frame(8'h03, 32'h44332211, 8'h00);
      idle(2);
      expect_result(3, 32'h44332211, 1'b1, 1'b0);
      chk("entry3_literal", cfg_values[3*EW +: EW], 32'h44332211);

      // Bad checksum (0x48 instead of 0x47)
      rdy_low = 0;
      send_frame(8'h03, 32'h44332211, 8'h0F);
      idle(2);
      expect_result(3, 32'h44332211, 1'b0, 1'b0);

      // Bad index
      rdy_low = 0;
      send_frame(8'h09, 32'h00000000, 8'h00);
      idle(2);
      expect_result(9, 32'h0, 1'b1, 1'b0);

      // Timeout after IDX, then a good frame to entry 2
      rdy_low = 0;
      send_byte(8'hA5);
      send_byte(8'h02);
      idle(TO + 2);
      expect_result(2, 32'h0, 1'b1, 1'b1);
      rdy_low = 0;
      send_frame(8'h02, 32'h00000001, 8'h00);
      idle(2);
      expect_result(2, 32'h00000001, 1'b1, 1'b0);

      // Noise then back-to-back frames
      rdy_low = 0;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame(8'h01, 32'h000000AA, 8'h00);
      send_frame(8'h01, 32'h00000055, 8'h00);
      idle(2);
      chk("b2b_events", evq.size(), 2);
      if (evq.size() == 2) begin
         e1 = evq.pop_front();
         e2 = evq.pop_front();
         chk("b2b_e1_err", e1.is_err, 1'b0);
         chk("b2b_e1_val", e1.val, 32'h000000AA);
         chk("b2b_e2_err", e2.is_err, 1'b0);
         chk("b2b_e2_idx", e2.idx, 1);
         chk("b2b_e2_val", e2.val, 32'h00000055);
         chk("b2b_spacing", e2.c - e1.c, NB + 4);
      end
      evq.delete();
      chk("b2b_ready_low", rdy_low, 2);
      mem[1] = 32'h00000055;
      check_bank();

      // Reset in the middle of a frame
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < NE; i++) mem[i] = '0;
      @(negedge clk);
      chk("midrst_ready_after", in_ready, 1'b1);
      @(posedge clk);
      #1;
      idle(2);
      chk("midrst_no_events", evq.size(), 0);
      check_bank();
      rdy_low = 0;
      send_frame(8'h04, 32'hCAFE0123, 8'h00);
      idle(2);
      expect_result(4, 32'hCAFE0123, 1'b1, 1'b0);

      // Randomized frames, noise and timeouts
      for (int k = 0; k < 40; k++) begin
         rdy_low = 0;
         m = $urandom_range(0, 2);
         for (int j = 0; j < m; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
         end
         r = $urandom_range(0, 9);
         if (r == 0) begin
            m = $urandom_range(0, NB + 1);
            send_byte(8'hA5);
            for (int j = 0; j < m; j++) send_byte(8'($urandom_range(0, 255)));
            idle(TO + 2);
            expect_result(0, 32'h0, 1'b1, 1'b1);
         end else begin
            idx  = $urandom_range(0, 11);
            d    = $urandom;
            flip = (r < 3) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(8'(idx), d, flip);
            idle(2);
            expect_result(idx, d, (flip == 8'h00), 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
